fifo_centroid_reader: RTL and testbench
=======================================

Name: fifo_centroid_reader

Overview:
Consumer end of the 17-bit camera pixel FIFO. The capture side pushes RGB565 pixels in raster order and pushes a frame marker word (bit 16 set) at each VSYNC.
This block drains the FIFO, tracks pixel position, and thresholds each pixel against a target colour. It accumulates coordinate sums and computes the target centroid once per frame with a sequential divider. Results drive the X_detect / Y_detect / xy_valid inputs of the VGA overlay.

Parameters:
H_RES, 320, pixels per line
V_RES, 240, lines per frame
R_MIN, 20, minimum 5-bit red component for a match
G_MAX, 24, maximum 6-bit green component for a match
B_MAX, 12, maximum 5-bit blue component for a match
MIN_PIXELS, 32, matched-pixel count below which the detection is invalid

Ports:
iCLK  in  1  system clock; all logic on rising edge
iRST_N  in  1  asynchronous active-low reset
fifo_dout  in  17  FIFO head word, first-word-fall-through; bit16=1 is the frame marker, else bits[15:0] are RGB565 {R[15:11],G[10:5],B[4:0]}
fifo_empty  in  1  FIFO empty; fifo_dout is valid when low
fifo_re  out  1  pop strobe; head word is consumed on the edge where fifo_re=1
X_detect  out  11  centroid column, zero-extended
Y_detect  out  10  centroid row, zero-extended
xy_valid  out  1  level; 1 = last completed frame had >= MIN_PIXELS matches
frame_done  out  1  one-cycle pulse when the outputs update
frame_err  out  1  one-cycle pulse, coincident with frame_done, when the frame pixel count != H_RES*V_RES

Behaviour:
- Reset (async, iRST_N=0): state=SYNC; all outputs, counters, sums and divider registers are 0.
- Combinational: fifo_re = !fifo_empty && (state==SYNC || state==RUN). No reads occur in DIV_X, DIV_Y or UPDATE; the FIFO absorbs the stall.
- SYNC: pops and discards words until a marker is popped, then clears x, y, sums, count and npix, and goes to RUN. Pixel words in SYNC are never accumulated.
- RUN, pixel popped:
  - Match = R>=R_MIN && G<=G_MAX && B<=B_MAX (unsigned).
  - If npix < H_RES*V_RES and the pixel matches: sum_x += x, sum_y += y, count += 1.
  - Position advances x+1; at x==H_RES-1, x wraps to 0 and y increments.
  - npix increments, saturating at 2^17-1.
  - Pixels beyond H_RES*V_RES are counted in npix but not accumulated.
- RUN, marker popped at edge T: the sums, count and npix are latched into the divider/result registers. The accumulators are cleared for the next frame in the same edge.
  - If latched count >= MIN_PIXELS: go to DIV_X.
  - Otherwise: go to UPDATE with the no-detection flag set.
- Widths: sum_x 26b, sum_y 25b, count 17b, npix 17b, x 9b, y 8b.
- DIV_X: 26-cycle restoring divider, one quotient bit per cycle, computing sum_x / count with truncation. Then DIV_Y: 26 cycles, sum_y / count. Then UPDATE.
- UPDATE (1 cycle), registering on its exit edge:
  - Valid detection: X_detect = qx[10:0], Y_detect = qy[9:0], xy_valid=1.
  - No detection: xy_valid=0; X_detect and Y_detect hold their previous values.
  - frame_done=1 for this one cycle.
  - frame_err=1 if latched npix != H_RES*V_RES.
  - Next state: RUN.
- Latency, valid path: outputs change on edge T+54 (1 + 26 + 26 + 1). No-detection path: edge T+2.
- Back-to-back markers (0 pixels): count=0, so no detection and frame_err=1.
- Marker already at the head during DIV/UPDATE: not popped until RUN is re-entered.
- Reset mid-operation (any state): immediate clear; the block returns to SYNC, and the partial frame and any in-flight division are discarded.
- Quotient cannot exceed H_RES-1 / V_RES-1 for in-range frames; truncation to 11/10 bits is by slicing.

Test Plan:
- Reset, then 500 pixels 16'hF800 with no marker, then marker + full green (16'h07E0) frame + marker -> pre-marker pixels ignored; xy_valid=0, X/Y=0; frame_done pulses once; frame_err=0.
- Marker, 76800 pixels with 16'hF800 in the 8x8 block x=100..107, y=50..57, rest 16'h07E0, marker -> X_detect=103, Y_detect=53, xy_valid=1, exactly 54 edges after the marker pop; frame_err=0.
- Following frame with only 10 red pixels -> xy_valid=0; X_detect=103 and Y_detect=53 held; frame_done 2 edges after the marker.
- Short frame (1000 pixels) -> frame_err=1. Long frame (76900 pixels, red pixels placed beyond 76800) -> those pixels are not accumulated; frame_err=1.
- Repeat the block-frame scenario with random fifo_empty gaps (50%) and the next marker queued during DIV -> identical results; fifo_re never high while empty or in DIV/UPDATE states.
- Assert iRST_N=0 during DIV_X -> all outputs 0 immediately; after release, the next full frame yields a correct centroid only after a fresh marker.

Source files
------------

// File: rtl/fifo_centroid_reader_if.sv
// FIFO consumer handshake plus centroid result bundle for fifo_centroid_reader.
// Handshake: fifo_dout is valid whenever fifo_empty=0 (first-word-fall-through);
// the head word is consumed on each rising edge where fifo_re=1, and fifo_re is
// only ever raised while fifo_empty=0. Results are registered.
interface fifo_centroid_reader_if;
  logic [16:0] fifo_dout;
  logic        fifo_empty;
  logic        fifo_re;
  logic [10:0] X_detect;
  logic [9:0]  Y_detect;
  logic        xy_valid;
  logic        frame_done;
  logic        frame_err;
  logic [2:0]  dbg_state;

  modport master (
    output fifo_dout, fifo_empty,
    input  fifo_re, X_detect, Y_detect, xy_valid, frame_done, frame_err, dbg_state
  );

  modport slave (
    input  fifo_dout, fifo_empty,
    output fifo_re, X_detect, Y_detect, xy_valid, frame_done, frame_err, dbg_state
  );
endinterface

// File: rtl/fifo_centroid_reader.sv
// Drains the camera pixel FIFO, thresholds pixels against a target colour and
// produces one centroid per frame using a sequential restoring divider.
module fifo_centroid_reader #(
  parameter int H_RES      = 320,
  parameter int V_RES      = 240,
  parameter int R_MIN      = 20,
  parameter int G_MAX      = 24,
  parameter int B_MAX      = 12,
  parameter int MIN_PIXELS = 32
) (
  input logic                  iCLK,
  input logic                  iRST_N,
  fifo_centroid_reader_if.slave bus
);

  typedef enum logic [2:0] {
    SYNC   = 3'd0,
    RUN    = 3'd1,
    EVAL   = 3'd2,
    DIV_X  = 3'd3,
    DIV_Y  = 3'd4,
    UPDATE = 3'd5
  } state_t;

  localparam logic [16:0] FRAME_PIX = 17'(H_RES * V_RES);
  localparam logic [8:0]  X_LAST    = 9'(H_RES - 1);
  localparam logic [16:0] NPIX_MAX  = '1;
  localparam logic [4:0]  DIV_LAST  = 5'd25;

  state_t      state;
  logic [8:0]  x;
  logic [7:0]  y;
  logic [25:0] sum_x;
  logic [24:0] sum_y;
  logic [16:0] count;
  logic [16:0] npix;

  logic [25:0] lat_sx;
  logic [24:0] lat_sy;
  logic [16:0] lat_cnt;
  logic [16:0] lat_npix;
  logic        nodet;

  logic [25:0] div_num;
  logic [16:0] div_rem;
  logic [4:0]  div_cnt;
  logic [10:0] qx;
  logic [9:0]  qy;

  logic        pop;
  logic        is_marker;
  logic        is_match;
  logic        in_range;
  logic [17:0] rem_sh;
  logic [17:0] rem_sub;
  logic        rem_ge;
  logic [16:0] rem_nx;
  logic [25:0] num_nx;
  logic        unused_rem_msb;

  assign bus.fifo_re   = !bus.fifo_empty && (state == SYNC || state == RUN);
  assign bus.dbg_state = state;
  assign pop           = bus.fifo_re;

  assign is_marker = bus.fifo_dout[16];
  assign is_match  = (bus.fifo_dout[15:11] >= 5'(R_MIN)) &&
                     (bus.fifo_dout[10:5]  <= 6'(G_MAX)) &&
                     (bus.fifo_dout[4:0]   <= 5'(B_MAX));
  assign in_range  = npix < FRAME_PIX;

  // Restoring step: remainder stays below the 17-bit divisor, so bit 17 of the
  // shifted remainder and of the difference is always zero once a bit is kept.
  assign rem_sh         = {div_rem, div_num[25]};
  assign rem_sub        = rem_sh - {1'b0, lat_cnt};
  assign rem_ge         = rem_sh >= {1'b0, lat_cnt};
  assign rem_nx         = rem_ge ? rem_sub[16:0] : rem_sh[16:0];
  assign num_nx         = {div_num[24:0], rem_ge};
  assign unused_rem_msb = rem_sub[17] ^ rem_sh[17];

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state          <= SYNC;
      x              <= '0;
      y              <= '0;
      sum_x          <= '0;
      sum_y          <= '0;
      count          <= '0;
      npix           <= '0;
      lat_sx         <= '0;
      lat_sy         <= '0;
      lat_cnt        <= '0;
      lat_npix       <= '0;
      nodet          <= 1'b0;
      div_num        <= '0;
      div_rem        <= '0;
      div_cnt        <= '0;
      qx             <= '0;
      qy             <= '0;
      bus.X_detect   <= '0;
      bus.Y_detect   <= '0;
      bus.xy_valid   <= 1'b0;
      bus.frame_done <= 1'b0;
      bus.frame_err  <= 1'b0;
    end else begin
      bus.frame_done <= 1'b0;
      bus.frame_err  <= 1'b0;
      case (state)
        SYNC: begin
          if (pop && is_marker) begin
            x     <= '0;
            y     <= '0;
            sum_x <= '0;
            sum_y <= '0;
            count <= '0;
            npix  <= '0;
            state <= RUN;
          end
        end

        RUN: begin
          if (pop) begin
            if (is_marker) begin
              lat_sx   <= sum_x;
              lat_sy   <= sum_y;
              lat_cnt  <= count;
              lat_npix <= npix;
              x        <= '0;
              y        <= '0;
              sum_x    <= '0;
              sum_y    <= '0;
              count    <= '0;
              npix     <= '0;
              state    <= EVAL;
            end else begin
              if (in_range && is_match) begin
                sum_x <= sum_x + 26'(x);
                sum_y <= sum_y + 25'(y);
                count <= count + 17'd1;
              end
              if (x == X_LAST) begin
                x <= '0;
                y <= y + 8'd1;
              end else begin
                x <= x + 9'd1;
              end
              if (npix != NPIX_MAX) begin
                npix <= npix + 17'd1;
              end
            end
          end
        end

        // Decision cycle on the latched count; the divider is primed either way.
        EVAL: begin
          div_num <= lat_sx;
          div_rem <= '0;
          div_cnt <= '0;
          if (lat_cnt >= 17'(MIN_PIXELS)) begin
            nodet <= 1'b0;
            state <= DIV_X;
          end else begin
            nodet <= 1'b1;
            state <= UPDATE;
          end
        end

        DIV_X: begin
          div_num <= num_nx;
          div_rem <= rem_nx;
          div_cnt <= div_cnt + 5'd1;
          if (div_cnt == DIV_LAST) begin
            qx      <= num_nx[10:0];
            div_num <= {1'b0, lat_sy};
            div_rem <= '0;
            div_cnt <= '0;
            state   <= DIV_Y;
          end
        end

        DIV_Y: begin
          div_num <= num_nx;
          div_rem <= rem_nx;
          div_cnt <= div_cnt + 5'd1;
          if (div_cnt == DIV_LAST) begin
            qy      <= num_nx[9:0];
            div_cnt <= '0;
            state   <= UPDATE;
          end
        end

        UPDATE: begin
          if (!nodet) begin
            bus.X_detect <= qx;
            bus.Y_detect <= qy;
            bus.xy_valid <= 1'b1;
          end else begin
            bus.xy_valid <= 1'b0;
          end
          bus.frame_done <= 1'b1;
          bus.frame_err  <= (lat_npix != FRAME_PIX);
          state          <= RUN;
        end

        default: state <= SYNC;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_centroid_reader.sv
// Self-checking bench for fifo_centroid_reader on a reduced 32x24 frame: a FIFO
// model feeds words, a frame-level reference computes the expected results.
module tb_fifo_centroid_reader;

  localparam int H         = 32;
  localparam int V         = 24;
  localparam int FRAME     = H * V;
  localparam int MINP      = 32;
  localparam int LAT_DET   = 54;
  localparam int LAT_NODET = 2;
  localparam logic [16:0] MARK  = 17'h10000;
  localparam logic [16:0] RED   = 17'h0F800;
  localparam logic [16:0] GREEN = 17'h007E0;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  fifo_centroid_reader_if bus();

  fifo_centroid_reader #(
    .H_RES(H), .V_RES(V), .R_MIN(20), .G_MAX(24), .B_MAX(12), .MIN_PIXELS(MINP)
  ) dut (
    .iCLK   (clk),
    .iRST_N (rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // FIFO model and drive registers
  logic [16:0] fifo_q[$];
  logic        drv_empty = 1'b1;
  logic [16:0] drv_dout  = '0;
  bit          gap_mode  = 1'b0;
  assign bus.fifo_empty = drv_empty;
  assign bus.fifo_dout  = drv_dout;

  // scoreboard: {done_edge[31:0], valid, err, x[10:0], y[9:0]}
  logic [54:0] exp_q[$];
  int n_cmp = 0;
  int n_fail = 0;

  // frame-level reference
  bit   m_sync = 1'b1;
  int   m_idx = 0, m_sx = 0, m_sy = 0, m_cnt = 0;
  int   busy_until = 0;
  logic [10:0] cur_x = '0;
  logic [9:0]  cur_y = '0;
  logic        cur_valid = 1'b0;
  logic        cur_err = 1'b0;

  // observation
  int   edge_n = 0;
  logic re_s = 1'b0, emp_s = 1'b1;
  int   done_cnt = 0, last_done_edge = 0, last_marker_edge = 0;
  logic last_done_err = 1'b0;

  task automatic check(input string name, input longint got, input longint want);
    n_cmp++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, want, $time);
    end
  endtask

  function automatic bit is_target(input logic [15:0] p);
    return (p[15:11] >= 5'd20) && (p[10:5] <= 6'd24) && (p[4:0] <= 5'd12);
  endfunction

  task automatic model_clear();
    m_idx = 0; m_sx = 0; m_sy = 0; m_cnt = 0;
  endtask

  task automatic model_reset();
    m_sync = 1'b1;
    model_clear();
    exp_q.delete();
    busy_until = 0;
    cur_x = '0; cur_y = '0; cur_valid = 1'b0; cur_err = 1'b0;
  endtask

  task automatic model_word(input logic [16:0] w, input int e);
    bit v;
    int ex, ey, d;
    if (m_sync) begin
      if (w[16]) begin
        m_sync = 1'b0;
        model_clear();
      end
    end else if (w[16]) begin
      v  = (m_cnt >= MINP);
      ex = v ? m_sx / m_cnt : 0;
      ey = v ? m_sy / m_cnt : 0;
      d  = e + (v ? LAT_DET : LAT_NODET);
      exp_q.push_back({32'(d), v, (m_idx != FRAME), 11'(ex), 10'(ey)});
      busy_until = d;
      last_marker_edge = e;
      model_clear();
    end else begin
      if (m_idx < FRAME && is_target(w[15:0])) begin
        m_sx += m_idx % H;
        m_sy += m_idx / H;
        m_cnt++;
      end
      m_idx++;
    end
  endtask

  always @(posedge clk) begin
    edge_n++;
    re_s  = bus.fifo_re;
    emp_s = bus.fifo_empty;
  end

  // pop bookkeeping, per-cycle output compare, then drive the next head word
  always @(negedge clk) begin : neg_proc
    logic [16:0] w;
    logic [54:0] e;
    bit due;
    w = '0;
    check("re_while_empty", re_s && emp_s, 0);
    if (re_s && !emp_s && fifo_q.size() > 0) begin
      w = fifo_q.pop_front();
      if (rst_n) begin
        check("pop_while_busy", edge_n <= busy_until, 0);
        model_word(w, edge_n);
      end
    end
    if (!rst_n) model_reset();

    while (exp_q.size() > 0 && int'(exp_q[0][54:23]) < edge_n) void'(exp_q.pop_front());
    due = 1'b0;
    if (exp_q.size() > 0 && int'(exp_q[0][54:23]) == edge_n) begin
      e = exp_q.pop_front();
      due = 1'b1;
      cur_valid = e[22];
      cur_err   = e[21];
      if (e[22]) begin
        cur_x = e[20:10];
        cur_y = e[9:0];
      end
    end
    n_cmp++;
    if (bus.X_detect !== cur_x || bus.Y_detect !== cur_y || bus.xy_valid !== cur_valid ||
        bus.frame_done !== due || bus.frame_err !== (due && cur_err)) begin
      n_fail++;
      $display("FAIL cycle_outputs edge %0d: got X=%0d Y=%0d v=%0d done=%0d err=%0d expected X=%0d Y=%0d v=%0d done=%0d err=%0d",
               edge_n, bus.X_detect, bus.Y_detect, bus.xy_valid, bus.frame_done, bus.frame_err,
               cur_x, cur_y, cur_valid, due, due && cur_err);
    end
    if (bus.frame_done === 1'b1) begin
      done_cnt++;
      last_done_edge = edge_n;
      last_done_err  = bus.frame_err;
    end

    if (!rst_n || fifo_q.size() == 0 || (gap_mode && $urandom_range(0, 1) == 1)) begin
      drv_empty = 1'b1;
      drv_dout  = 17'($urandom);
    end else begin
      drv_empty = 1'b0;
      drv_dout  = fifo_q[0];
    end
  end

  task automatic push_frame(input int x0, input int y0, input int bw, input int bh, input int n);
    for (int i = 0; i < n; i++) begin
      int px, py;
      px = i % H;
      py = i / H;
      fifo_q.push_back((px >= x0 && px < x0 + bw && py >= y0 && py < y0 + bh) ? RED : GREEN);
    end
  endtask

  task automatic push_random_frame();
    logic [15:0] bnd [4];
    bnd[0] = 16'hA30C;  // R=20 G=24 B=12
    bnd[1] = 16'h9800;  // R=19
    bnd[2] = 16'hFB20;  // G=25
    bnd[3] = 16'hF80D;  // B=13
    for (int i = 0; i < FRAME; i++) begin
      int r;
      r = $urandom_range(0, 7);
      if (r == 0)
        fifo_q.push_back({1'b0, 5'($urandom_range(20, 31)), 6'($urandom_range(0, 24)),
                          5'($urandom_range(0, 12))});
      else if (r == 1)
        fifo_q.push_back({1'b0, bnd[$urandom_range(0, 3)]});
      else
        fifo_q.push_back({1'b0, 16'($urandom)});
    end
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while (!(fifo_q.size() == 0 && exp_q.size() == 0 && edge_n > busy_until) && k < 8000) begin
      @(posedge clk);
      k++;
    end
    check({tag, "_idle"}, k < 8000, 1);
    repeat (3) @(posedge clk);
  endtask

  task automatic check_out(input string tag, input int xv, input int yv, input int v);
    check({tag, "_X"}, bus.X_detect, xv);
    check({tag, "_Y"}, bus.Y_detect, yv);
    check({tag, "_valid"}, bus.xy_valid, v);
  endtask

  initial begin
    int k;
    repeat (3) @(posedge clk);
    #1;
    check_out("reset", 0, 0, 0);
    check("reset_done", bus.frame_done, 0);
    check("reset_err", bus.frame_err, 0);
    check("reset_re", bus.fifo_re, 0);
    @(negedge clk);
    #2 rst_n = 1'b1;

    // pre-marker pixels are dropped, then an all-green frame
    @(posedge clk);
    for (int i = 0; i < 50; i++) fifo_q.push_back(RED);
    fifo_q.push_back(MARK);
    push_frame(-100, -100, 0, 0, FRAME);
    fifo_q.push_back(MARK);
    wait_idle("s1");
    check_out("s1", 0, 0, 0);
    check("s1_done_cnt", done_cnt, 1);
    check("s1_err", last_done_err, 0);

    // 8x8 block at x=10..17, y=5..12
    push_frame(10, 5, 8, 8, FRAME);
    fifo_q.push_back(MARK);
    wait_idle("s2");
    check_out("s2", 13, 8, 1);
    check("s2_err", last_done_err, 0);
    check("s2_latency", last_done_edge - last_marker_edge, 54);

    // only 10 matches: invalid, coordinates held
    push_frame(3, 3, 10, 1, FRAME);
    fifo_q.push_back(MARK);
    wait_idle("s3");
    check_out("s3", 13, 8, 0);
    check("s3_latency", last_done_edge - last_marker_edge, 2);
    check("s3_done_cnt", done_cnt, 3);

    // short frame
    push_frame(0, 0, 8, 8, 100);
    fifo_q.push_back(MARK);
    wait_idle("s4");
    check("s4_err", last_done_err, 1);

    // long frame: red pixels past the frame end are ignored
    push_frame(20, 2, 8, 8, FRAME);
    for (int i = 0; i < 100; i++) fifo_q.push_back(RED);
    fifo_q.push_back(MARK);
    wait_idle("s5");
    check_out("s5", 23, 5, 1);
    check("s5_err", last_done_err, 1);

    // random frame then block frame, all queued, with 50% empty gaps
    gap_mode = 1'b1;
    push_random_frame();
    fifo_q.push_back(MARK);
    push_frame(10, 5, 8, 8, FRAME);
    fifo_q.push_back(MARK);
    wait_idle("s6");
    gap_mode = 1'b0;
    check_out("s6", 13, 8, 1);
    check("s6_done_cnt", done_cnt, 7);

    // reset while dividing
    push_frame(20, 2, 8, 8, FRAME);
    fifo_q.push_back(MARK);
    k = 0;
    while (fifo_q.size() != 0 && k < 4000) begin
      @(posedge clk);
      k++;
    end
    check("s7_drain", k < 4000, 1);
    repeat (8) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_out("s7_rst", 0, 0, 0);
    check("s7_rst_done", bus.frame_done, 0);
    check("s7_rst_err", bus.frame_err, 0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;

    // a frame without a leading marker must not count
    @(posedge clk);
    push_frame(20, 2, 8, 8, FRAME);
    fifo_q.push_back(MARK);
    push_frame(10, 5, 8, 8, FRAME);
    fifo_q.push_back(MARK);
    wait_idle("s8");
    check_out("s8", 13, 8, 1);
    check("s8_done_cnt", done_cnt, 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1500000;
    n_fail++;
    $display("FAIL watchdog: got time limit reached expected bench completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
